// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM arbiter: FSM encoding, request-code bit positions, bank ids.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    // Layout of each core's 2-bit read/write code
    localparam int REQ_BIT  = 0;
    localparam int BANK_BIT = 1;

    localparam logic BANK_OPERAND = 1'b0;
    localparam logic BANK_RESULT  = 1'b1;

    // Width of a core index; a single-bit index is kept even for tiny arrays
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// Round-robin picker: first unmasked requester at or after ptr, wrapping past the top index.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the winner.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [N-1:0]     eligible;
    logic [IDX_W-1:0] cand;

    assign eligible = req & ~mask;

    // Walk the candidates starting at ptr; the first eligible one wins
    always_comb begin
        vld  = 1'b0;
        idx  = '0;
        cand = ptr;
        for (int i = 0; i < N; i++) begin
            if (!vld && eligible[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Serialises per-core DRAM requests onto one single-port DRAM with round-robin arbitration.
// Latency: read strobe t+1, data and o_ready t+3; write strobe t+1, o_ready t+2 (t = IDLE sample cycle).
// Backpressure: a core holds its request level until its o_ready pulse; nothing is queued.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_CORES*ADDR_W-1:0]   i_req_addr,
    input  logic [N_CORES*2-1:0]        i_req_read,
    input  logic [N_CORES*2-1:0]        i_req_write,
    input  logic [N_CORES*DATA_W-1:0]   i_req_wdata,
    output logic [N_CORES*DATA_W-1:0]   o_rdata,
    output logic [N_CORES-1:0]          o_ready,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic                        o_mem_bank,
    output logic                        o_mem_re,
    output logic                        o_mem_we,
    output logic [DATA_W-1:0]           o_mem_wdata,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    output logic                        o_err
);

    localparam int               IDX_W    = idx_width(N_CORES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CORES - 1);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [N_CORES-1:0]  req_vec;
    logic [N_CORES-1:0]  mask;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    grant;
    logic [N_CORES-1:0]  grant_onehot;
    logic                op_write;
    logic                pick_vld;
    logic [IDX_W-1:0]    pick_idx;
    logic [1:0]          sel_rd;
    logic [1:0]          sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    assign grant_onehot = N_CORES'(1) << grant;

    // A core is requesting when either code carries its request bit
    always_comb begin
        req_vec = '0;
        for (int k = 0; k < N_CORES; k++) begin
            req_vec[k] = i_req_read[k*2 + REQ_BIT] | i_req_write[k*2 + REQ_BIT];
        end
    end

    rr_picker #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_picker (
        .req  (req_vec),
        .mask (mask),
        .ptr  (ptr),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    // Route the picked core's request bundle to the latch point
    always_comb begin
        sel_rd    = '0;
        sel_wr    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                sel_rd    = i_req_read[k*2 +: 2];
                sel_wr    = i_req_write[k*2 +: 2];
                sel_addr  = i_req_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = i_req_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: reads take the CAPTURE detour, writes go straight to RESP
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = op_write ? RESP : CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered datapath: latch the grant, drive one strobe, capture data, pulse ready
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mem_re    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_bank  <= BANK_OPERAND;
            o_mem_wdata <= '0;
            o_ready     <= '0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            ptr         <= '0;
            mask        <= '0;
            grant       <= '0;
            op_write    <= 1'b0;
        end else begin
            o_mem_re <= 1'b0;
            o_mem_we <= 1'b0;
            o_ready  <= '0;
            case (state)
                IDLE: begin
                    // The post-RESP mask only covers this first IDLE cycle
                    mask <= '0;
                    if (pick_vld) begin
                        // Read+write together resolves to a write on the write-code bank
                        grant       <= pick_idx;
                        op_write    <= sel_wr[REQ_BIT];
                        o_mem_addr  <= sel_addr;
                        o_mem_bank  <= sel_wr[REQ_BIT] ? sel_wr[BANK_BIT] : sel_rd[BANK_BIT];
                        o_mem_wdata <= sel_wdata;
                        o_mem_re    <= ~sel_wr[REQ_BIT];
                        o_mem_we    <= sel_wr[REQ_BIT];
                        if (sel_rd[REQ_BIT] && sel_wr[REQ_BIT]) begin
                            o_err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (op_write) begin
                        o_ready <= grant_onehot;
                    end
                end
                CAPTURE: begin
                    for (int k = 0; k < N_CORES; k++) begin
                        if (grant == IDX_W'(k)) begin
                            o_rdata[k*DATA_W +: DATA_W] <= i_mem_rdata;
                        end
                    end
                    o_ready <= grant_onehot;
                end
                RESP: begin
                    ptr  <= (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
                    mask <= grant_onehot;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios then random traffic against a transaction-level model.
// Latency: the model schedules strobe/ready/data cycles from each predicted grant.
// Backpressure: bench cores hold requests until their predicted ready, optionally two cycles longer.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N*AW-1:0]   i_req_addr;
    logic [N*2-1:0]    i_req_read;
    logic [N*2-1:0]    i_req_write;
    logic [N*DW-1:0]   i_req_wdata;
    logic [N*DW-1:0]   o_rdata;
    logic [N-1:0]      o_ready;
    logic [AW-1:0]     o_mem_addr;
    logic              o_mem_bank;
    logic              o_mem_re;
    logic              o_mem_we;
    logic [DW-1:0]     o_mem_wdata;
    logic [DW-1:0]     i_mem_rdata;
    logic              o_err;

    dram_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_addr  (i_req_addr),
        .i_req_read  (i_req_read),
        .i_req_write (i_req_write),
        .i_req_wdata (i_req_wdata),
        .o_rdata     (o_rdata),
        .o_ready     (o_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_bank  (o_mem_bank),
        .o_mem_re    (o_mem_re),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Bench-side cores
    logic [1:0]    c_rd    [N];
    logic [1:0]    c_wr    [N];
    logic [AW-1:0] c_addr  [N];
    logic [DW-1:0] c_wdata [N];
    bit            c_hold  [N];
    int            c_drop  [N];

    // DRAM contents behind the DUT, and the reference copy used for predictions
    logic [DW-1:0] dram    [512];
    logic [DW-1:0] ref_mem [512];

    // Transaction-level model state
    int            cyc, free_cyc, mask_cyc, mask_core, m_ptr;
    bit            t_vld, t_wr;
    int            t_start, t_g;
    logic [AW-1:0] t_addr;
    logic          t_bank;
    logic [DW-1:0] t_wdata, t_rdata;
    logic [N*DW-1:0] exp_rdata;
    logic          exp_err;

    int            served[$];
    int            served_cyc[$];
    int            n_tests, n_fail;

    function automatic int midx(input logic b, input logic [AW-1:0] a);
        return int'({b, a[7:0]});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            i_req_read[k*2 +: 2]    = c_rd[k];
            i_req_write[k*2 +: 2]   = c_wr[k];
            i_req_addr[k*AW +: AW]  = c_addr[k];
            i_req_wdata[k*DW +: DW] = c_wdata[k];
        end
    endtask

    task automatic post(input int k, input logic [1:0] rd, input logic [1:0] wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
        c_rd[k] = rd; c_wr[k] = wr; c_addr[k] = a; c_wdata[k] = d;
        c_hold[k] = hold; c_drop[k] = -1;
    endtask

    task automatic model_reset();
        t_vld = 1'b0; exp_rdata = '0; exp_err = 1'b0;
        m_ptr = 0; free_cyc = 0; mask_cyc = -1; mask_core = 0;
        for (int k = 0; k < N; k++) post(k, 2'b00, 2'b00, '0, '0, 1'b0);
    endtask

    // Grant prediction: first requester at or after the pointer, skipping the core just served
    task automatic decide();
        bit found;
        int g, k, rdy;
        drive();
        if (!i_rst && cyc >= free_cyc) begin
            found = 1'b0; g = 0;
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (!found && (c_rd[k][0] || c_wr[k][0]) && !(cyc == mask_cyc && k == mask_core)) begin
                    found = 1'b1; g = k;
                end
            end
            if (found) begin
                t_vld = 1'b1; t_start = cyc; t_g = g; t_wr = c_wr[g][0];
                t_bank  = t_wr ? c_wr[g][1] : c_rd[g][1];
                t_addr  = c_addr[g]; t_wdata = c_wdata[g];
                if (c_rd[g][0] && c_wr[g][0]) exp_err = 1'b1;
                if (t_wr) ref_mem[midx(t_bank, t_addr)] = t_wdata;
                else      t_rdata = ref_mem[midx(t_bank, t_addr)];
                rdy       = cyc + (t_wr ? 2 : 3);
                free_cyc  = rdy + 1;
                mask_cyc  = free_cyc;
                mask_core = g;
                m_ptr     = (g + 1) % N;
                c_drop[g] = rdy + (c_hold[g] ? 2 : 0);
            end
        end
    endtask

    task automatic check_cycle();
        logic          exp_re, exp_we;
        logic [N-1:0]  exp_rdy;
        int            rdy;
        exp_re = 1'b0; exp_we = 1'b0; exp_rdy = '0;
        if (t_vld) begin
            rdy = t_start + (t_wr ? 2 : 3);
            if (cyc == t_start + 1) begin exp_re = !t_wr; exp_we = t_wr; end
            if (cyc == rdy) exp_rdy = N'(1) << t_g;
            if (!t_wr && cyc == rdy) exp_rdata[t_g*DW +: DW] = t_rdata;
        end
        chk("mem_re", 64'(o_mem_re), 64'(exp_re));
        chk("mem_we", 64'(o_mem_we), 64'(exp_we));
        chk("ready", 64'(o_ready), 64'(exp_rdy));
        chk("rdata", 64'(o_rdata), 64'(exp_rdata));
        chk("err", 64'(o_err), 64'(exp_err));
        if (exp_re || exp_we) begin
            chk("mem_addr", 64'(o_mem_addr), 64'(t_addr));
            chk("mem_bank", 64'(o_mem_bank), 64'(t_bank));
            if (exp_we) chk("mem_wdata", 64'(o_mem_wdata), 64'(t_wdata));
        end
        for (int k = 0; k < N; k++) begin
            if (o_ready[k]) begin served.push_back(k); served_cyc.push_back(cyc); end
        end
    endtask

    // The DRAM itself: writes land on the strobe, read data appears for the following cycle
    task automatic serve_mem();
        if (o_mem_we) dram[midx(o_mem_bank, o_mem_addr)] = o_mem_wdata;
        if (o_mem_re) i_mem_rdata = dram[midx(o_mem_bank, o_mem_addr)];
    endtask

    task automatic drop_reqs();
        for (int k = 0; k < N; k++) begin
            if ((c_rd[k][0] || c_wr[k][0]) && c_drop[k] == cyc) post(k, 2'b00, 2'b00, '0, '0, 1'b0);
        end
    endtask

    task automatic tick();
        decide();
        @(negedge i_clk);
        cyc++;
        check_cycle();
        serve_mem();
        drop_reqs();
    endtask

    task automatic reset_mid(input int k, input logic [1:0] rd, input logic [1:0] wr, input int n_before);
        post(k, rd, wr, 16'h0010, 8'h3C, 1'b0);
        repeat (n_before) tick();
        i_rst = 1'b1;
        #1;
        chk("rst_mem_re", 64'(o_mem_re), 64'(0));
        chk("rst_mem_we", 64'(o_mem_we), 64'(0));
        chk("rst_ready", 64'(o_ready), 64'(0));
        chk("rst_rdata", 64'(o_rdata), 64'(0));
        model_reset();
        drive();
        repeat (2) tick();
        chk("rst_mem_addr", 64'(o_mem_addr), 64'(0));
        i_rst = 1'b0;
        tick();
    endtask

    initial begin
        int exp_order[5];
        bit reposted;
        logic [DW-1:0] v;
        int op;
        exp_order = '{0, 1, 2, 3, 0};
        n_tests = 0; n_fail = 0; cyc = 0;
        i_mem_rdata = '0;
        for (int i = 0; i < 512; i++) begin
            v = DW'($urandom);
            dram[i] = v; ref_mem[i] = v;
        end
        i_rst = 1'b1;
        model_reset();
        drive();
        repeat (2) tick();
        chk("reset_addr", 64'(o_mem_addr), 64'(0));
        chk("reset_bank", 64'(o_mem_bank), 64'(0));
        chk("reset_wdata", 64'(o_mem_wdata), 64'(0));
        i_rst = 1'b0;
        tick();

        // Single read: core 1, address 0x0123, operand bank, memory returns 0x5A
        dram[midx(1'b0, 16'h0123)] = 8'h5A;
        ref_mem[midx(1'b0, 16'h0123)] = 8'h5A;
        post(1, 2'b01, 2'b00, 16'h0123, 8'h00, 1'b0);
        repeat (5) tick();
        chk("read_data_core1", 64'(o_rdata[15:8]), 64'h5A);

        // Single write: core 2, 0xC3 to 0x0040 in the result bank
        post(2, 2'b00, {BANK_RESULT, 1'b1}, 16'h0040, 8'hC3, 1'b0);
        repeat (4) tick();
        chk("write_landed", 64'(dram[midx(1'b1, 16'h0040)]), 64'hC3);

        // Mask/wrap: core 3 lingers past its ready while core 0 waits
        served.delete(); served_cyc.delete();
        post(3, 2'b01, 2'b00, 16'h0055, 8'h00, 1'b1);
        post(0, 2'b01, 2'b00, 16'h0066, 8'h00, 1'b0);
        repeat (12) tick();
        chk("wrap_count", 64'(served.size()), 64'(2));
        if (served.size() == 2) begin
            chk("wrap_first", 64'(served[0]), 64'(3));
            chk("wrap_second", 64'(served[1]), 64'(0));
        end

        // Read and write together: treated as a write to the write-code bank, error sticks
        post(0, 2'b01, 2'b11, 16'h0077, 8'h99, 1'b0);
        repeat (3) tick();
        repeat (10) tick();
        chk("err_sticky", 64'(o_err), 64'(1));
        chk("err_write_landed", 64'(dram[midx(1'b1, 16'h0077)]), 64'h99);

        // Reset while a read sits in CAPTURE, then while a write strobe is up
        reset_mid(2, 2'b01, 2'b00, 2);
        reset_mid(1, 2'b00, 2'b01, 1);

        // Contention: four reads at once from ptr 0; core 0 re-requests as soon as it is served
        served.delete(); served_cyc.delete();
        for (int k = 0; k < N; k++) post(k, 2'b01, 2'b00, 16'h0200 + 16'(k), 8'h00, 1'b0);
        reposted = 1'b0;
        repeat (24) begin
            tick();
            if (!reposted && served.size() >= 1 && c_rd[0] == 2'b00) begin
                post(0, 2'b01, 2'b00, 16'h0300, 8'h00, 1'b0);
                reposted = 1'b1;
            end
        end
        chk("order_count", 64'(served.size()), 64'(5));
        for (int i = 0; i < 5 && i < served.size(); i++) begin
            chk("order_core", 64'(served[i]), 64'(exp_order[i]));
            if (i > 0) chk("order_spacing", 64'(served_cyc[i] - served_cyc[i-1]), 64'(4));
        end

        // Random traffic from all cores
        repeat (800) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (c_rd[k] == 2'b00 && c_wr[k] == 2'b00 && $urandom_range(0, 2) == 0) begin
                    op = int'($urandom_range(0, 1));
                    post(k,
                         (op == 0) ? {1'($urandom_range(0, 1)), 1'b1} : 2'b00,
                         (op == 1) ? {1'($urandom_range(0, 1)), 1'b1} : 2'b00,
                         AW'($urandom), DW'($urandom), $urandom_range(0, 3) == 0);
                end
            end
        end
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shared data-memory arbiter that sits directly downstream of the array of `core` instances. It takes each core's DRAM request bundle (address, 2-bit read/write codes, write data) and serialises the requests onto one single-port synchronous DRAM using round-robin arbitration. It returns read data and a per-core completion pulse (`o_ready`), which each core's control unit waits on before it continues.

## Interface

Parameters:
- `N_CORES`, default 4: number of requesting cores, 2..8.
- `ADDR_W`, default 16: DRAM address width, matching the core's `o_dram_addr`.
- `DATA_W`, default 8: DRAM data width, matching the core's `o_dram_out` and `i_dram_in`.

Ports:
- `i_clk`  in  1: system clock; the same `i_clk` that feeds the cores.
- `i_rst`  in  1: reset, asynchronous, active-high.
- `i_req_addr`  in  N_CORES*ADDR_W: per-core address; core k occupies slice [k*ADDR_W +: ADDR_W].
- `i_req_read`  in  N_CORES*2: per-core read code. Bit0 is the request; bit1 is the bank (0 = operand bank, 1 = result bank).
- `i_req_write`  in  N_CORES*2: per-core write code, same encoding as `i_req_read`.
- `i_req_wdata`  in  N_CORES*DATA_W: per-core write data.
- `o_rdata`  out  N_CORES*DATA_W: per-core read-data holding registers.
- `o_ready`  out  N_CORES: one-cycle completion pulse per core.
- `o_mem_addr`  out  ADDR_W: DRAM address.
- `o_mem_bank`  out  1: DRAM bank select.
- `o_mem_re`  out  1: DRAM read strobe.
- `o_mem_we`  out  1: DRAM write strobe.
- `o_mem_wdata`  out  DATA_W: DRAM write data.
- `i_mem_rdata`  in  DATA_W: DRAM read data. It is valid on the cycle after `o_mem_re` is high.
- `o_err`  out  1: sticky flag set when a core asserts read and write together.

## Operation

Request semantics:
- Core k is requesting when `read[0] | write[0]` is set and k is not masked.
- A core holds its request stable until it sees its `o_ready` pulse.
- A core drops its request on the cycle after `o_ready`.

State machine (`IDLE`, `ISSUE`, `CAPTURE`, `RESP`):
- IDLE: pick the winner with the round-robin picker, starting from `ptr`. If there is a winner, latch grant index g, the address, the bank, the write data and the op, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: drive `o_mem_addr`/`o_mem_bank` and assert exactly one of `o_mem_re`/`o_mem_we` for one cycle. Go to CAPTURE for a read, RESP for a write.
- CAPTURE: load `i_mem_rdata` into `o_rdata[g]`, then go to RESP.
- RESP: pulse `o_ready[g]`, set `ptr = (g+1) mod N_CORES`, set the one-cycle mask for core g, then go to IDLE.

Rules:
- Mask: core g is ineligible during the first IDLE cycle after its RESP. This prevents re-granting a request that is being dropped. The mask clears after that cycle.
- Read and write asserted together by one core: the request is treated as a write, using the write-code bank, and `o_err` sets. `o_err` clears only on reset.
- `o_rdata[k]` holds its value until the next read completes for core k. Writes never change `o_rdata`.
- `ptr` wraps from N_CORES-1 to 0.
- A request arriving while the arbiter is busy waits. There is no queue depth; pending state is the request level itself.

## Timing

- Reset values: state IDLE, `ptr` 0, mask 0, `o_ready` 0, `o_rdata` all 0, `o_mem_re`/`o_mem_we` 0, `o_mem_addr`/`o_mem_wdata`/`o_mem_bank` 0, `o_err` 0.
- Reset mid-operation aborts the access. Strobes fall asynchronously and no `o_ready` is issued.
- Read latency: a request sampled in IDLE at cycle t gives `o_mem_re` at t+1, `o_rdata[g]` valid at t+3, and `o_ready[g]` high at t+3.
- Write latency: `o_mem_we` at t+1 and `o_ready[g]` at t+2.
- Throughput: one read per 4 cycles (IDLE, ISSUE, CAPTURE, RESP); one write per 3 cycles.
- All outputs are registered. The picker is combinational and only in the IDLE path.
- Cores register state on `~i_clk`, so they sample `o_ready` half a cycle after it rises.

## Structure

- Package `dram_arb_pkg` holds:
  - the state encoding (`IDLE`=0, `ISSUE`=1, `CAPTURE`=2, `RESP`=3);
  - the code bit positions `REQ_BIT`=0 and `BANK_BIT`=1;
  - the bank constants `BANK_OPERAND`=0 and `BANK_RESULT`=1.
- Sub-module `rr_picker`: combinational.
  - Inputs: request vector, mask and `ptr`.
  - Outputs: a valid flag and the winner index. The winner is the first requester at or after `ptr`, with wrap-around.

## Test plan

- Single read: after reset, core 1 requests a read at 0x0123 in bank 0 while the memory model returns 0x5A. Expect `o_mem_re` at t+1 with `o_mem_addr`=0x0123, then `o_rdata[1]`=0x5A and `o_ready[1]` at t+3. No other `o_ready` bit rises.
- Single write: core 2 writes 0xC3 to 0x0040 in bank 1. Expect `o_mem_we` at t+1 with `o_mem_bank`=1 and `o_mem_wdata`=0xC3, and `o_ready[2]` at t+2. `o_rdata` is unchanged.
- Contention: all 4 cores request reads in the same cycle with `ptr`=0. Expect grants in order 0,1,2,3, with `o_ready` pulses 4 cycles apart. A re-request by core 0 after all four is served next.
- Mask/wrap: core 3 holds its request for one extra cycle after `o_ready[3]` while core 0 is also requesting. Expect core 0 granted next, `ptr` wrapping 3→0, and no second grant to core 3.
- Error: core 0 asserts `read`=01 and `write`=11 together. Expect a write to bank 1, `o_err`=1, and `o_err` still high 10 cycles later.
- Reset mid-read: assert `i_rst` during CAPTURE. Expect `o_mem_re`=0 immediately, no `o_ready`, `o_rdata` all 0, and state IDLE after release.
